// File: rtl/bayer_quad_rgb_if.sv
// Pixel-side bundle between the line-delay stage and the Bayer quad demosaic.
// The master drives pixels and strobes; the slave returns the half-resolution RGB stream.
interface bayer_quad_rgb_if #(
  parameter int N = 12
);
  logic         enable;
  logic         frame_start;
  logic [15:0]  line_width;
  logic [N-1:0] pix_cur;
  logic [N-1:0] pix_prev;
  logic         out_valid;
  logic [N-1:0] r;
  logic [N-1:0] g;
  logic [N-1:0] b;
  logic [14:0]  out_x;
  logic [14:0]  out_y;

  modport master (
    output enable, frame_start, line_width, pix_cur, pix_prev,
    input  out_valid, r, g, b, out_x, out_y
  );

  modport slave (
    input  enable, frame_start, line_width, pix_cur, pix_prev,
    output out_valid, r, g, b, out_x, out_y
  );
endinterface

// File: rtl/bayer_quad_rgb.sv
// Builds 2x2 Bayer quads from the live pixel and the line-delayed pixel above it,
// emitting one RGB pixel per quad with its quad coordinates.
module bayer_quad_rgb #(
  parameter int N             = 12,
  parameter int BAYER_PATTERN = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  bayer_quad_rgb_if.slave bus
);

  logic [15:0]  x, y, lw_reg;
  logic [N-1:0] cur_d, prev_d;

  logic [15:0]  xs, ys, lw;
  logic         last_col, emit;
  logic [N-1:0] p00, p01, p10, p11;
  logic [N:0]   g_sum;
  logic [N-1:0] r_n, g_n, b_n;

  // A frame_start coinciding with enable makes this pixel (0,0) under the new width.
  always_comb begin
    xs       = bus.frame_start ? 16'd0 : x;
    ys       = bus.frame_start ? 16'd0 : y;
    lw       = bus.frame_start ? bus.line_width : lw_reg;
    last_col = (lw < 16'd2) || (xs == lw - 16'd1);
    emit     = bus.enable && xs[0] && ys[0] && (lw >= 16'd2);

    p00 = prev_d;
    p01 = bus.pix_prev;
    p10 = cur_d;
    p11 = bus.pix_cur;

    g_sum = '0;
    r_n   = '0;
    b_n   = '0;
    case (BAYER_PATTERN)
      0: begin
        r_n   = p00;
        g_sum = {1'b0, p01} + {1'b0, p10};
        b_n   = p11;
      end
      1: begin
        r_n   = p01;
        g_sum = {1'b0, p00} + {1'b0, p11};
        b_n   = p10;
      end
      2: begin
        r_n   = p10;
        g_sum = {1'b0, p00} + {1'b0, p11};
        b_n   = p01;
      end
      default: begin
        r_n   = p11;
        g_sum = {1'b0, p01} + {1'b0, p10};
        b_n   = p00;
      end
    endcase
    g_n = g_sum[N:1];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x             <= '0;
      y             <= '0;
      lw_reg        <= '0;
      cur_d         <= '0;
      prev_d        <= '0;
      bus.out_valid <= 1'b0;
      bus.r         <= '0;
      bus.g         <= '0;
      bus.b         <= '0;
      bus.out_x     <= '0;
      bus.out_y     <= '0;
    end else begin
      bus.out_valid <= emit;
      if (bus.frame_start) begin
        lw_reg <= bus.line_width;
        x      <= '0;
        y      <= '0;
      end
      if (bus.enable) begin
        cur_d  <= bus.pix_cur;
        prev_d <= bus.pix_prev;
        if (last_col) begin
          x <= '0;
          y <= ys + 16'd1;
        end else begin
          x <= xs + 16'd1;
        end
      end
      // Outputs hold between quads.
      if (emit) begin
        bus.r     <= r_n;
        bus.g     <= g_n;
        bus.b     <= b_n;
        bus.out_x <= xs[15:1];
        bus.out_y <= ys[15:1];
      end
    end
  end

endmodule
